uart_rx_fifo: RTL and testbench

- Oversampling UART receive front end sitting directly upstream of the peripheral register block.
- Recovers 8N1 frames from the asynchronous serial pin and buffers received bytes in a small first-word-fall-through FIFO.
- The peripheral pops bytes into its receive-data register and reads status flags for its control register.
- Replaces the bare one-byte receive path, so back-to-back frames are not lost while software is slow to read.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_fifo_if.sv | 45 ++++
 rtl/uart_byte_fifo.sv | 80 ++++++++
 rtl/uart_rx_fifo.sv | 205 ++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive front end.
//   state_t    : receive FSM states (PARITY is used only when the design is
//                built with UART_RX_PARITY_EN defined)
//   DATA_BITS  : payload bits per frame
//   DEF_*      : default clock, baud and oversampling values
//   calc_div   : clk cycles per oversample tick (integer floor)
package uart_pkg;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int DATA_BITS      = 8;
    localparam int DEF_CLK_FREQ   = 100_000_000;
    localparam int DEF_BAUD       = 9600;
    localparam int DEF_OVERSAMPLE = 16;

    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receive-side bus between the UART receiver and the peripheral register block.
//   rd_en      : pop request for the FIFO head (driven by the consumer)
//   rx_data    : FIFO head byte, valid while rx_valid = 1
//   rx_valid   : FIFO not empty
//   rx_full    : FIFO holds FIFO_DEPTH bytes
//   rx_count   : FIFO occupancy
//   frame_err  : one-cycle pulse, stop bit sampled low
//   overrun    : one-cycle pulse, good byte dropped because the FIFO was full
//   parity_err : one-cycle pulse, bad even parity (only with UART_RX_PARITY_EN)
// Modports: master = receiver side, slave = consumer side.
interface uart_rx_fifo_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          rd_en;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_full;
    logic [CW-1:0] rx_count;
    logic          frame_err;
    logic          overrun;
`ifdef UART_RX_PARITY_EN
    logic          parity_err;

    modport master (
        input  rd_en,
        output rx_data, rx_valid, rx_full, rx_count, frame_err, overrun, parity_err
    );
    modport slave (
        output rd_en,
        input  rx_data, rx_valid, rx_full, rx_count, frame_err, overrun, parity_err
    );
`else
    modport master (
        input  rd_en,
        output rx_data, rx_valid, rx_full, rx_count, frame_err, overrun
    );
    modport slave (
        output rd_en,
        input  rx_data, rx_valid, rx_full, rx_count, frame_err, overrun
    );
`endif

endinterface

// File: rtl/uart_byte_fifo.sv
// First-word-fall-through byte FIFO with a registered head.
// Ports:
//   clk, reset (async active-low)
//   push, din   : write request and byte
//   pop         : read request, ignored while empty
//   dout        : registered head byte
//   valid, full, count : status
//   overrun     : one-cycle pulse when a push is dropped (full, no pop)
module uart_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [7:0]                 din,
    input  logic                       pop,
    output logic [7:0]                 dout,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [7:0]    head;
    logic          overrun_q;
    logic          pop_eff;
    logic          push_eff;
    logic [CW-1:0] remain;

    assign full     = (cnt == CW'(DEPTH));
    assign valid    = (cnt != '0);
    assign pop_eff  = pop && valid;
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // still lands.
    assign push_eff = push && (!full || pop_eff);
    // Entries left after this cycle's pop, before this cycle's push.
    assign remain   = cnt - CW'(pop_eff);

    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            head      <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr + AW'(push_eff);
            rd_ptr    <= rd_ptr + AW'(pop_eff);
            cnt       <= cnt + CW'(push_eff) - CW'(pop_eff);
            overrun_q <= push && full && !pop_eff;
            // Keep the head register equal to the oldest stored byte: the
            // incoming byte if it lands in an otherwise empty FIFO, else the
            // next entry after a pop.
            if (remain == '0) begin
                if (push_eff) begin
                    head <= din;
                end
            end else if (pop_eff) begin
                head <= mem[rd_ptr + AW'(1)];
            end
        end
    end

    assign dout    = head;
    assign count   = cnt;
    assign overrun = overrun_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling 8N1 UART receiver feeding a small FWFT byte FIFO.
// Optional even-parity support is compiled in with UART_RX_PARITY_EN.
// Ports:
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   rx     : raw serial line, idle high, asynchronous to clk
//   bus    : uart_rx_fifo_if.master (rd_en in; rx_data, rx_valid, rx_full,
//            rx_count, frame_err, overrun [, parity_err] out)
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = DEF_CLK_FREQ,
    parameter int BAUD       = DEF_BAUD,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rx,
    uart_rx_fifo_if.master bus
);
    localparam int DIV   = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PH_W  = $clog2(OVERSAMPLE);
    localparam int M     = OVERSAMPLE / 2;
    localparam int BI_W  = $clog2(DATA_BITS);

    state_t               state;
    state_t               state_n;
    logic                 rx_meta;
    logic                 rxs;
    logic [DIV_W-1:0]     div_cnt;
    logic                 tick;
    logic [PH_W-1:0]      ph;
    logic                 samp_a;
    logic                 samp_b;
    logic                 maj;
    logic                 decide;
    logic                 bit_end;
    logic                 start_edge;
    logic [BI_W-1:0]      bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 push;
    logic                 frame_err_c;
    logic                 frame_err_q;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
    logic                 parity_err_c;
    logic                 parity_err_q;
`endif

    // Two-flop synchroniser; resets to the idle level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Oversample tick divider, re-phased to the detected start edge.
    assign start_edge = (state == IDLE) && !rxs;
    assign tick       = (div_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (start_edge || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Bit value is the majority of the samples at ph = M-1, M and the live
    // sample at ph = M+1, taken on the decision tick.
    assign maj     = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
    assign decide  = tick && (ph == PH_W'(M + 1));
    assign bit_end = tick && (ph == PH_W'(OVERSAMPLE - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= WAIT_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            WAIT_IDLE: if (tick && rxs) state_n = IDLE;
            IDLE:      if (!rxs) state_n = START;
            START: begin
                if (decide && maj) begin
                    state_n = IDLE;
                end else if (bit_end) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_idx == BI_W'(DATA_BITS - 1))) begin
`ifdef UART_RX_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY:    if (bit_end) state_n = STOP;
`endif
            // Leave at the stop decision so an early next start edge is seen.
            STOP:      if (decide) state_n = maj ? IDLE : WAIT_IDLE;
            default:   state_n = WAIT_IDLE;
        endcase
    end

    always_comb begin
        push        = 1'b0;
        frame_err_c = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_c = 1'b0;
`endif
        if ((state == STOP) && decide) begin
            if (!maj) frame_err_c = 1'b1;
`ifdef UART_RX_PARITY_EN
            else if ((^shreg) ^ par_bit) parity_err_c = 1'b1;
`endif
            else push = 1'b1;
        end
    end

    // Bit timing and shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph      <= '0;
            samp_a  <= 1'b1;
            samp_b  <= 1'b1;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            if ((state == IDLE) || (state == WAIT_IDLE)) begin
                ph <= '0;
            end else if (tick) begin
                ph <= (ph == PH_W'(OVERSAMPLE - 1)) ? '0 : ph + PH_W'(1);
            end
            if (tick && (ph == PH_W'(M - 1))) samp_a <= rxs;
            if (tick && (ph == PH_W'(M)))     samp_b <= rxs;
            if (state == START) begin
                bit_idx <= '0;
            end else if ((state == DATA) && bit_end) begin
                bit_idx <= bit_idx + BI_W'(1);
            end
            // LSB arrives first, so shift in from the top.
            if ((state == DATA) && decide) begin
                shreg <= {maj, shreg[DATA_BITS-1:1]};
            end
`ifdef UART_RX_PARITY_EN
            if ((state == PARITY) && decide) par_bit <= maj;
`endif
        end
    end

    // Status pulses are registered to line up with the FIFO update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q  <= frame_err_c;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_c;
`endif
        end
    end

    assign bus.frame_err  = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`endif

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .din     (shreg),
        .pop     (bus.rd_en),
        .dout    (bus.rx_data),
        .valid   (bus.rx_valid),
        .full    (bus.rx_full),
        .count   (bus.rx_count),
        .overrun (bus.overrun)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo. Uses a fast clock/baud ratio (3 clk per
// tick, 16 ticks per bit) so each frame is a few hundred cycles.
// Parity steps are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx_fifo;

    localparam int CLK_FREQ = 460800;
    localparam int BAUD     = 9600;
    localparam int OS       = 16;
    localparam int DEPTH    = 4;
    localparam int DIV      = CLK_FREQ / (BAUD * OS);
    localparam int BIT      = DIV * OS;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // Edge (counted from the edge after which rx falls) at which the push is
    // registered: 2 sync flops + 1 edge for the IDLE->START decision, then
    // the stop decision tick at ph = OS/2+1 of the last bit.
    localparam int PUSH_EDGE = 3 + DIV * ((FRAME_BITS - 1) * OS + OS / 2 + 2);

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic rx    = 1'b1;

    int vectors    = 0;
    int miscompares = 0;
    int ovr_cnt  = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int both_cnt = 0;
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.overrun)   ovr_cnt  <= ovr_cnt + 1;
        if (bus.frame_err) ferr_cnt <= ferr_cnt + 1;
        if (bus.overrun && bus.frame_err) both_cnt <= both_cnt + 1;
`ifdef UART_RX_PARITY_EN
        if (bus.parity_err) perr_cnt <= perr_cnt + 1;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one frame starting now; leaves rx at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        repeat (BIT) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT) @(posedge clk);
            #1;
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ par_flip;
        repeat (BIT) @(posedge clk);
        #1;
`endif
        rx = stop;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, 32'(bus.rx_valid), 32'd1);
        check({tag, "_data"}, 32'(bus.rx_data), 32'(exp));
        bus.rd_en = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_en = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rd_en = 1'b0;

        // Reset state and idle line
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_count", 32'(bus.rx_count), 32'd0);
        check("rst_full", 32'(bus.rx_full), 32'd0);
        check("rst_data", 32'(bus.rx_data), 32'd0);
        check("rst_ferr", 32'(bus.frame_err), 32'd0);
        check("rst_ovr", 32'(bus.overrun), 32'd0);
        reset = 1'b1;
        repeat (2 * FRAME_BITS * BIT) @(posedge clk);
        #1;
        check("idle_valid", 32'(bus.rx_valid), 32'd0);
        check("idle_count", 32'(bus.rx_count), 32'd0);
        check("idle_pulses", 32'(ovr_cnt + ferr_cnt + perr_cnt), 32'd0);

        // Single frame 0xA5 with latency probe
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat ((FRAME_BITS - 1) * BIT + BIT / 2) @(posedge clk);
                #1;
                check("a5_early_valid", 32'(bus.rx_valid), 32'd0);
            end
        join
        check("a5_count", 32'(bus.rx_count), 32'd1);
        pop_check("a5", 8'hA5);
        check("a5_popped_valid", 32'(bus.rx_valid), 32'd0);
        check("a5_popped_count", 32'(bus.rx_count), 32'd0);
        bus.rd_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.rd_en = 1'b0;
        check("empty_pop_count", 32'(bus.rx_count), 32'd0);
        check("empty_pop_valid", 32'(bus.rx_valid), 32'd0);

        // Reset asserted mid-frame while the FIFO holds data
        send_frame(8'h5A, 1'b1);
        check("pre_rst_valid", 32'(bus.rx_valid), 32'd1);
        rx = 1'b0;
        repeat (3 * BIT) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.rx_valid), 32'd0);
        check("midrst_count", 32'(bus.rx_count), 32'd0);
        check("midrst_full", 32'(bus.rx_full), 32'd0);
        check("midrst_data", 32'(bus.rx_data), 32'd0);
        check("midrst_ferr", 32'(bus.frame_err), 32'd0);
        check("midrst_ovr", 32'(bus.overrun), 32'd0);
        rx = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2 * FRAME_BITS * BIT) @(posedge clk);
        #1;
        check("postrst_count", 32'(bus.rx_count), 32'd0);
        check("postrst_pulses", 32'(ovr_cnt + ferr_cnt), 32'd0);

        // Five back-to-back frames, no reads
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        check("fill_full", 32'(bus.rx_full), 32'd1);
        check("fill_count", 32'(bus.rx_count), 32'd4);
        check("fill_ovr", 32'(ovr_cnt), 32'd0);
        send_frame(8'h05, 1'b1);
        check("ovr_pulses", 32'(ovr_cnt), 32'd1);
        check("ovr_count", 32'(bus.rx_count), 32'd4);
        pop_check("ovr_pop1", 8'h01);
        pop_check("ovr_pop2", 8'h02);
        pop_check("ovr_pop3", 8'h03);
        pop_check("ovr_pop4", 8'h04);
        check("ovr_drained", 32'(bus.rx_valid), 32'd0);

        // Short glitch is a false start
        rx = 1'b0;
        repeat (4 * DIV) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (2 * BIT) @(posedge clk);
        #1;
        check("glitch_count", 32'(bus.rx_count), 32'd0);
        check("glitch_ferr", 32'(ferr_cnt), 32'd0);

        // Bad stop bit, line held low afterwards
        send_frame(8'h3C, 1'b0);
        repeat (12 * BIT) @(posedge clk);
        #1;
        check("ferr_pulses", 32'(ferr_cnt), 32'd1);
        check("ferr_count", 32'(bus.rx_count), 32'd0);
        rx = 1'b1;
        repeat (BIT) @(posedge clk);
        #1;

        // Recovery frame with rd_en in the push cycle of an empty FIFO
        fork
            send_frame(8'h5A, 1'b1);
            begin
                repeat (PUSH_EDGE - 1) @(posedge clk);
                #1;
                bus.rd_en = 1'b1;
                @(posedge clk);
                #1;
                bus.rd_en = 1'b0;
            end
        join
        check("empty_pushpop_count", 32'(bus.rx_count), 32'd1);
        pop_check("recover", 8'h5A);

        // Full FIFO, pop in the exact push cycle of 0x77
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        check("full2_full", 32'(bus.rx_full), 32'd1);
        fork
            send_frame(8'h77, 1'b1);
            begin
                repeat (PUSH_EDGE - 1) @(posedge clk);
                #1;
                bus.rd_en = 1'b1;
                @(posedge clk);
                #1;
                bus.rd_en = 1'b0;
            end
        join
        check("full_pushpop_ovr", 32'(ovr_cnt), 32'd1);
        check("full_pushpop_count", 32'(bus.rx_count), 32'd4);
        pop_check("fp_pop1", 8'h22);
        pop_check("fp_pop2", 8'h33);
        pop_check("fp_pop3", 8'h44);
        pop_check("fp_pop4", 8'h77);
        check("fp_drained", 32'(bus.rx_valid), 32'd0);

`ifdef UART_RX_PARITY_EN
        par_flip = 1'b1;
        send_frame(8'h03, 1'b1);
        check("par_bad_pulses", 32'(perr_cnt), 32'd1);
        check("par_bad_count", 32'(bus.rx_count), 32'd0);
        par_flip = 1'b0;
        send_frame(8'h03, 1'b1);
        check("par_good_count", 32'(bus.rx_count), 32'd1);
        pop_check("par_good", 8'h03);
`endif

        check("ferr_ovr_overlap", 32'(both_cnt), 32'd0);
        check("total_ferr", 32'(ferr_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
